// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared operation/state encodings and default sizes for muldiv_unit.
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Low two bits of the op field; bit 2 is the signed flag.
    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } muldiv_state_t;

    // True for the two operations that use the shift-add datapath.
    function automatic logic is_mul(input muldiv_op_t op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for arfcpu.
// It computes one result bit per cycle, with a fixed latency of XLEN+1 cycles
// from accept to the register-bank write. MUL and MULH use shift-add.
// DIV and REM use restoring division. All four share one 2*XLEN work register.
// Optional build macro: MULDIV_SIGNED_EN. When it is defined, op[2] selects the
// signed variants. When it is undefined, every operation is unsigned.
module muldiv_unit #(
    parameter int XLEN       = muldiv_pkg::XLEN,
    parameter int REG_ADDR_W = muldiv_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [XLEN-1:0]       operand_a,
    input  logic [XLEN-1:0]       operand_b,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  busy,
    output logic                  done,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [XLEN-1:0]       write_data,
    output logic                  write_enable
);
    import muldiv_pkg::*;

    localparam int CNT_W = $clog2(XLEN);

    muldiv_state_t         state, state_next;
    logic [CNT_W-1:0]      cnt;
    logic [2*XLEN-1:0]     work, work_next;
    logic [XLEN-1:0]       divisor;
    muldiv_op_t            op_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic                  accept, last_iter;
    logic [XLEN-1:0]       a_mag, b_mag;
    logic [XLEN:0]         add_sum, part_rem, trial;
    logic [XLEN-1:0]       result;

`ifdef MULDIV_SIGNED_EN
    logic              a_neg, b_neg, a_neg_q, b_neg_q;
    logic [2*XLEN-1:0] prod_fix;

    assign a_neg = op[2] & operand_a[XLEN-1];
    assign b_neg = op[2] & operand_b[XLEN-1];
    assign a_mag = a_neg ? -operand_a : operand_a;
    assign b_mag = b_neg ? -operand_b : operand_b;
`else
    assign a_mag = operand_a;
    assign b_mag = operand_b;
`endif

    assign accept       = (state == ST_IDLE) && start;
    assign last_iter    = (state == ST_RUN) && (cnt == '0);
    assign write_enable = done;

    // State register.
    // NOTE: registers update only with non-blocking assignment (<=). Every flop then samples pre-edge values, and the order of the blocks does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next state, busy and the done strobe.
    // NOTE: every output of this block gets a default first. A path that skips an assignment would otherwise infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_RUN;
            end
            ST_RUN:  if (cnt == '0) state_next = ST_DONE;
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // One iteration: a shift-add product step, or one restoring-division step.
    always_comb begin
        add_sum  = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, divisor} : '0);
        part_rem = work[2*XLEN-1:XLEN-1];
        trial    = part_rem - {1'b0, divisor};
        if (is_mul(op_q))
            work_next = {add_sum, work[XLEN-1:1]};
        else if (!trial[XLEN])
            work_next = {trial[XLEN-1:0], work[XLEN-2:0], 1'b1};
        else
            work_next = {part_rem[XLEN-1:0], work[XLEN-2:0], 1'b0};
    end

    // Pick the result word from the final work value and fix its sign.
    // A zero divisor keeps the all-ones quotient unchanged.
    always_comb begin
        result = '0;
`ifdef MULDIV_SIGNED_EN
        prod_fix = (a_neg_q ^ b_neg_q) ? -work_next : work_next;
        case (op_q)
            OP_MUL:  result = prod_fix[XLEN-1:0];
            OP_MULH: result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV:  result = ((a_neg_q ^ b_neg_q) && (divisor != '0))
                              ? -work_next[XLEN-1:0] : work_next[XLEN-1:0];
            OP_REM:  result = a_neg_q ? -work_next[2*XLEN-1:XLEN] : work_next[2*XLEN-1:XLEN];
        endcase
`else
        case (op_q)
            OP_MUL, OP_DIV:  result = work_next[XLEN-1:0];
            OP_MULH, OP_REM: result = work_next[2*XLEN-1:XLEN];
        endcase
`endif
    end

    // Capture operands on accept, iterate in RUN, and register the write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            work       <= '0;
            divisor    <= '0;
            op_q       <= OP_MUL;
            dest_q     <= '0;
            write_reg  <= '0;
            write_data <= '0;
`ifdef MULDIV_SIGNED_EN
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
`endif
        end else if (accept) begin
            cnt     <= CNT_W'(XLEN - 1);
            work    <= {{XLEN{1'b0}}, a_mag};
            divisor <= b_mag;
            op_q    <= muldiv_op_t'(op[1:0]);
            dest_q  <= dest_reg;
`ifdef MULDIV_SIGNED_EN
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
`endif
        end else if (state == ST_RUN) begin
            work <= work_next;
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            if (last_iter) begin
                write_data <= result;
                write_reg  <= dest_q;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// Directed vectors are taken from a table. Expected write-backs go into a
// scoreboard queue, and a monitor compares them when write_enable fires.
// Signed vectors are added only when MULDIV_SIGNED_EN is defined.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int LAT  = XLEN + 1;
    localparam int GAP  = XLEN + 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_a, operand_b;
    logic [RW-1:0]   dest_reg;
    logic            busy, done, write_enable;
    logic [RW-1:0]   write_reg;
    logic [XLEN-1:0] write_data;

    muldiv_unit #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .dest_reg     (dest_reg),
        .busy         (busy),
        .done         (done),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .write_enable (write_enable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [RW-1:0]   dest;
        logic [XLEN-1:0] want;
        string           name;
    } vec_t;

    typedef struct {
        logic [RW-1:0]   dest;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] want);
        n_total++;
        if (actual === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, want, $time);
    endtask

    // Scoreboard monitor: every write-back must match the oldest pending request.
    exp_t e;
    always @(negedge clk) begin
        if (rst_n && write_enable) begin
            if (sb.size() == 0) begin
                check("spurious_write_enable", write_enable, 0);
            end else begin
                e = sb.pop_front();
                check("write_data", write_data, e.data);
                check("write_reg", write_reg, e.dest);
                check("done_eq_we", done, write_enable);
            end
        end
    end

    // Issue one request while idle, scramble the inputs after accept, and check latency and the pulse width.
    task automatic run_op(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [RW-1:0] d, input logic [XLEN-1:0] want, input string name);
        int cyc;
        @(negedge clk);
        check({name, "_idle_before"}, busy, 0);
        op = o; operand_a = a; operand_b = b; dest_reg = d; start = 1'b1;
        sb.push_back('{d, want});
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); operand_a = $urandom; operand_b = $urandom; dest_reg = RW'($urandom);
        cyc = 1;
        check({name, "_busy"}, busy, 1);
        while (!write_enable && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency"}, cyc, LAT);
        @(negedge clk);
        check({name, "_done_one_cycle"}, done, 0);
        check({name, "_idle_after"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int dones;
        int done_run;
        int accepts[$];
        logic prev_busy;

        // Vector table.
        vecs.push_back('{3'b000, 32'h0001_0000, 32'h0001_0000, 5'd1,  32'h0000_0000, "mul_2p16"});
        vecs.push_back('{3'b001, 32'h0001_0000, 32'h0001_0000, 5'd2,  32'h0000_0001, "mulh_2p16"});
        vecs.push_back('{3'b000, 32'd3,         32'd5,         5'd0,  32'd15,        "mul_small_r0"});
        vecs.push_back('{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0001, "mul_max"});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, "mulh_max"});
        vecs.push_back('{3'b010, 32'd100,       32'd7,         5'd5,  32'd14,        "divu_100_7"});
        vecs.push_back('{3'b011, 32'd100,       32'd7,         5'd6,  32'd2,         "remu_100_7"});
        vecs.push_back('{3'b010, 32'h0000_1234, 32'd0,         5'd7,  32'hFFFF_FFFF, "divu_by0"});
        vecs.push_back('{3'b011, 32'h0000_1234, 32'd0,         5'd8,  32'h0000_1234, "remu_by0"});
        vecs.push_back('{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h0000_0000, "divu_big"});
        vecs.push_back('{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, "remu_big"});
`ifdef MULDIV_SIGNED_EN
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFD, "div_m7_2"});
        vecs.push_back('{3'b111, 32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFF, "rem_m7_2"});
        vecs.push_back('{3'b111, 32'd7,         32'hFFFF_FFFE, 5'd13, 32'd1,         "rem_7_m2"});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, "div_ovf"});
        vecs.push_back('{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, "rem_ovf"});
        vecs.push_back('{3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, "mulh_m1_m1"});
        vecs.push_back('{3'b100, 32'hFFFF_FFFD, 32'd5,         5'd17, 32'hFFFF_FFF1, "mul_m3_5"});
        vecs.push_back('{3'b101, 32'hFFFF_FFFD, 32'd5,         5'd18, 32'hFFFF_FFFF, "mulh_m3_5"});
        vecs.push_back('{3'b110, 32'hFFFF_FFF8, 32'd0,         5'd19, 32'hFFFF_FFFF, "div_m8_by0"});
        vecs.push_back('{3'b111, 32'hFFFF_FFF8, 32'd0,         5'd20, 32'hFFFF_FFF8, "rem_m8_by0"});
`else
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'h7FFF_FFFC, "div_flag_ignored"});
        vecs.push_back('{3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, "mulh_flag_ignored"});
`endif

        // Reset state.
        rst_n = 1'b0; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; dest_reg = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", write_enable, 0);
        check("rst_write_reg", write_reg, 0);
        check("rst_write_data", write_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].want, vecs[i].name);

        // Second start during RUN is dropped. The result belongs to the first request.
        @(negedge clk);
        op = 3'b010; operand_a = 32'd1000; operand_b = 32'd3; dest_reg = 5'd21; start = 1'b1;
        sb.push_back('{5'd21, 32'd333});
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin @(negedge clk); cyc++; end
        op = 3'b000; operand_a = 32'd9; operand_b = 32'd9; dest_reg = 5'd22; start = 1'b1;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        while (!write_enable && cyc < 100) begin @(negedge clk); cyc++; end
        check("ignored_start_latency", cyc, LAT);
        repeat (3) @(negedge clk);
        check("ignored_start_not_queued", busy, 0);

        // Reset at cycle 20 of RUN discards the operation.
        @(negedge clk);
        op = 3'b000; operand_a = 32'd6; operand_b = 32'd7; dest_reg = 5'd23; start = 1'b1;
        sb.push_back('{5'd23, 32'd42});
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 20) begin @(negedge clk); cyc++; end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_write_data", write_data, 0);
        check("midrst_write_reg", write_reg, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_stays_idle", busy, 0);
        run_op(3'b000, 32'd6, 32'd7, 5'd23, 32'd42, "after_rst");

        // Back-to-back with start held high: accepts every XLEN+2 cycles.
        @(negedge clk);
        op = 3'b010; operand_a = 32'd1000; operand_b = 32'd10; dest_reg = 5'd24; start = 1'b1;
        repeat (3) sb.push_back('{5'd24, 32'd100});
        cyc = 0; dones = 0; done_run = 0; prev_busy = busy;
        while (dones < 3 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (busy && !prev_busy) begin
                accepts.push_back(cyc);
                if (accepts.size() == 3) start = 1'b0;
            end
            if (done) done_run++;
            else if (done_run > 0) begin
                check("b2b_done_width", done_run, 1);
                dones++;
                done_run = 0;
            end
            prev_busy = busy;
        end
        check("b2b_done_count", dones, 3);
        if (accepts.size() == 3) begin
            check("b2b_gap_1", accepts[1] - accepts[0], GAP);
            check("b2b_gap_2", accepts[2] - accepts[1], GAP);
        end else begin
            check("b2b_accept_count", accepts.size(), 3);
        end
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
